microwave_timer_ctrl: RTL

- Sequencing controller for the microwave countdown chain: minutes digit, mod-6 seconds-tens digit and mod-10 seconds-units digit.
- Collects keypad digits into a 3-digit BCD entry buffer and loads the buffer into the chain.
- Generates the one-second count enables and watches the chain's all-zero flag.
- Drives the magnetron and the end-of-cook beeper; sits between the keypad/button front end and the counter chain.

---
 rtl/microwave_timer_ctrl_if.sv | 26 ++
 rtl/microwave_timer_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl_if.sv
// microwave_timer_ctrl_if: front-end buttons, keypad and countdown-chain signals of the microwave timer controller.
interface microwave_timer_ctrl_if;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_zero;
  logic [3:0] data_min;
  logic [3:0] data_tens;
  logic [3:0] data_units;
  logic       timer_loadn;
  logic       timer_clrn;
  logic       timer_enable;
  logic       mag_on;
  logic       beep;
  logic [2:0] state;
  modport master (
    output startn, stopn, door_closed, key_valid, key_code, timer_zero,
    input  data_min, data_tens, data_units, timer_loadn, timer_clrn, timer_enable, mag_on, beep, state
  );
  modport slave (
    input  startn, stopn, door_closed, key_valid, key_code, timer_zero,
    output data_min, data_tens, data_units, timer_loadn, timer_clrn, timer_enable, mag_on, beep, state
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, cook sequencing, one-second ticks and beeper for a BCD countdown chain.
// Define DOOR_INTERLOCK_EN to pause cooking and gate the magnetron whenever the door opens.
module microwave_timer_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input logic                 clock,
  input logic                 clrn,
  microwave_timer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, COOKING, PAUSED, DONE} state_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_TICKS + 1);
  state_t        cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [BW-1:0] beep_cnt;
  logic start_q, stop_q, start_ev, stop_ev, key_ok, clr_buf, wrap, cook_first, buf_zero, door_trip, door_ok;
`ifdef DOOR_INTERLOCK_EN
  assign door_trip = ~bus.door_closed;
  assign door_ok   = bus.door_closed;
`else
  assign door_trip = 1'b0;
  assign door_ok   = 1'b1;
`endif
  assign bus.state = cur;
  assign start_ev  = start_q & ~bus.startn;
  assign stop_ev   = stop_q & ~bus.stopn;
  assign wrap      = presc == PW'(TICK_DIV - 1);
  assign buf_zero  = {bus.data_min, bus.data_tens, bus.data_units} == 12'd0;
  // A units digit above 5 cannot shift into the mod-6 tens position.
  assign key_ok    = (cur == IDLE || cur == ENTRY) && bus.key_valid && bus.key_code <= 4'd9 &&
                     bus.data_units <= 4'd5 && !stop_ev;
  always_comb begin
    nxt     = cur;
    clr_buf = 1'b0;
    case (cur)
      IDLE:    nxt = key_ok ? ENTRY : IDLE;
      ENTRY: begin
        clr_buf = stop_ev;
        nxt     = stop_ev ? IDLE : (!key_ok && start_ev && !buf_zero && bus.door_closed) ? LOAD : ENTRY;
      end
      LOAD:    nxt = COOKING;
      COOKING: nxt = (stop_ev || door_trip) ? PAUSED : (!cook_first && bus.timer_zero) ? DONE : COOKING;
      PAUSED: begin
        clr_buf = stop_ev;
        nxt     = stop_ev ? IDLE : (start_ev && bus.door_closed) ? COOKING : PAUSED;
      end
      DONE: begin
        clr_buf = stop_ev || (wrap && beep_cnt == BW'(BEEP_TICKS - 1));
        nxt     = clr_buf ? IDLE : DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  // The prescaler advances on every COOKING cycle so a pause resumes mid-second; DONE restarts it for an exact beep length.
  assign presc_nxt = (cur == LOAD || (cur == COOKING && nxt == DONE)) ? '0 :
                     (cur == COOKING || cur == DONE) ? (wrap ? '0 : presc + 1'b1) : presc;
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cur              <= IDLE;
      presc            <= '0;
      beep_cnt         <= '0;
      start_q          <= 1'b1;
      stop_q           <= 1'b1;
      cook_first       <= 1'b0;
      bus.data_min     <= 4'd0;
      bus.data_tens    <= 4'd0;
      bus.data_units   <= 4'd0;
      bus.timer_loadn  <= 1'b1;
      bus.timer_clrn   <= 1'b0;
      bus.timer_enable <= 1'b0;
      bus.mag_on       <= 1'b0;
      bus.beep         <= 1'b0;
    end else begin
      cur              <= nxt;
      presc            <= presc_nxt;
      beep_cnt         <= cur != DONE ? '0 : wrap ? beep_cnt + 1'b1 : beep_cnt;
      start_q          <= bus.startn;
      stop_q           <= bus.stopn;
      cook_first       <= nxt == COOKING && cur != COOKING;
      bus.data_min     <= clr_buf ? 4'd0 : key_ok ? bus.data_tens : bus.data_min;
      bus.data_tens    <= clr_buf ? 4'd0 : key_ok ? bus.data_units : bus.data_tens;
      bus.data_units   <= clr_buf ? 4'd0 : key_ok ? bus.key_code : bus.data_units;
      bus.timer_loadn  <= nxt != LOAD;
      bus.timer_clrn   <= !(cur == PAUSED && stop_ev);
      bus.timer_enable <= nxt == COOKING && presc_nxt == PW'(TICK_DIV - 1);
      bus.mag_on       <= nxt == COOKING && door_ok;
      bus.beep         <= nxt == DONE;
    end
  end
endmodule
